// File: rtl/testio_host_fsm.sv
// Host-side sequencer for the testio transceiver: takes one request at a time,
// steps ti_ctrl through the write/read frame and reports a completion.
module testio_host_fsm #(
  parameter int WR_HOST_CYC = 71,
  parameter int RD_HOST_CYC = 35,
  parameter int RD_TARG_CYC = 33,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       ti_clk,
  input  logic       ti_rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_type,
  output logic       req_type_q,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_err,
  output logic       resp_timeout,
  input  logic       trx_resp_data_err,
  input  logic [5:0] ti_fsm_ctrl,
  output logic [5:0] ti_ctrl,
  output logic       busy
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_WR_SEND    = 4'd1;
  localparam logic [3:0] S_RD_SEND    = 4'd2;
  localparam logic [3:0] S_WAIT_START = 4'd3;
  localparam logic [3:0] S_WR_ACK     = 4'd4;
  localparam logic [3:0] S_WR_STOP    = 4'd5;
  localparam logic [3:0] S_RD_RCV     = 4'd6;
  localparam logic [3:0] S_RD_DRAIN   = 4'd7;
  localparam logic [3:0] S_RESP       = 4'd8;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic       w_rcv_start, w_rcv_ack, w_rcv_stop, w_rcv_done, w_send_done;
  logic [3:0] r_state, w_state_nxt;
  logic       r_entry, w_entry_nxt;
  logic       r_req_type_q, w_type_nxt;
  logic       r_ack_err, w_ack_err_nxt;
  logic       r_to_flag, w_to_flag_nxt;
  logic [7:0] r_to_cnt, w_to_cnt_nxt;
  logic [5:0] r_ti_ctrl;
  logic       r_req_ready, r_busy, r_resp_valid, r_resp_timeout;
  logic       r_resp_ack_err, r_resp_rd_chk;
  logic       w_unused;

  assign w_rcv_start = ti_fsm_ctrl[5];
  assign w_rcv_ack   = ti_fsm_ctrl[4];
  assign w_rcv_stop  = ti_fsm_ctrl[2];
  assign w_rcv_done  = ti_fsm_ctrl[1];
  assign w_send_done = ti_fsm_ctrl[0];

  // Reload lengths belong to the transceiver and parity is folded into its data error.
  assign w_unused = ti_fsm_ctrl[3] ^ (^(WR_HOST_CYC ^ RD_HOST_CYC ^ RD_TARG_CYC));

  function automatic logic [5:0] ctrl_decode(input logic [3:0] st, input logic ent);
    logic [5:0] c;
    c    = 6'b000000;
    c[5] = ent;
    case (st)
      S_WR_SEND: begin
        c[4] = 1'b1;
        c[1] = 1'b1;
        c[0] = ~ent;
      end
      S_RD_SEND: begin
        c[3] = 1'b1;
        c[1] = 1'b1;
        c[0] = ~ent;
      end
      S_RD_RCV: begin
        c[2] = 1'b1;
        c[0] = ~ent;
      end
      S_RD_DRAIN: c[2] = 1'b1;
      default:    c[4:0] = 5'b00000;
    endcase
    return c;
  endfunction

  // Next-state and transaction-flag logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_type_nxt    = r_req_type_q;
    w_ack_err_nxt = r_ack_err;
    w_to_flag_nxt = r_to_flag;
    w_to_cnt_nxt  = r_to_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt   = req_type ? S_WR_SEND : S_RD_SEND;
          w_type_nxt    = req_type;
          w_ack_err_nxt = 1'b0;
          w_to_flag_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_SEND, S_RD_SEND: begin
        // During the entry cycle send_done reflects the previous frame's counter.
        if (w_send_done && !r_entry) begin
          w_state_nxt  = S_WAIT_START;
          w_to_cnt_nxt = 8'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WAIT_START: begin
        w_to_cnt_nxt = r_to_cnt + 8'd1;
        if (w_rcv_start) begin
          w_state_nxt = r_req_type_q ? S_WR_ACK : S_RD_RCV;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt   = S_RESP;
          w_to_flag_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_START;
        end
      end
      S_WR_ACK: begin
        w_ack_err_nxt = ~w_rcv_ack;
        w_state_nxt   = S_WR_STOP;
      end
      S_WR_STOP: begin
        w_ack_err_nxt = r_ack_err | ~w_rcv_stop;
        w_state_nxt   = S_RESP;
      end
      S_RD_RCV: begin
        if (w_rcv_done && !r_entry) begin
          w_state_nxt = S_RD_DRAIN;
        end else begin
          w_state_nxt = S_RD_RCV;
        end
      end
      S_RD_DRAIN: w_state_nxt = S_RESP;
      S_RESP:     w_state_nxt = resp_ready ? S_IDLE : S_RESP;
      default:    w_state_nxt = S_IDLE;
    endcase
    w_entry_nxt = (w_state_nxt != r_state);
  end

  // State, flags and outputs, all registered from the next-state values.
  always_ff @(posedge ti_clk or negedge ti_rstn) begin
    if (!ti_rstn) begin
      r_state        <= S_IDLE;
      r_entry        <= 1'b0;
      r_req_type_q   <= 1'b0;
      r_ack_err      <= 1'b0;
      r_to_flag      <= 1'b0;
      r_to_cnt       <= 8'd0;
      r_ti_ctrl      <= 6'b000000;
      r_req_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_resp_ack_err <= 1'b0;
      r_resp_rd_chk  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_entry        <= w_entry_nxt;
      r_req_type_q   <= w_type_nxt;
      r_ack_err      <= w_ack_err_nxt;
      r_to_flag      <= w_to_flag_nxt;
      r_to_cnt       <= w_to_cnt_nxt;
      r_ti_ctrl      <= ctrl_decode(w_state_nxt, w_entry_nxt);
      r_req_ready    <= (w_state_nxt == S_IDLE);
      r_busy         <= (w_state_nxt != S_IDLE);
      r_resp_valid   <= (w_state_nxt == S_RESP);
      r_resp_timeout <= (w_state_nxt == S_RESP) & w_to_flag_nxt;
      r_resp_ack_err <= (w_state_nxt == S_RESP) & w_ack_err_nxt;
      r_resp_rd_chk  <= (w_state_nxt == S_RESP) & ~w_type_nxt & ~w_to_flag_nxt;
    end
  end

  // The transceiver's data error settles during the drain cycle, so it is gated live.
  assign resp_err     = r_resp_ack_err | (r_resp_rd_chk & trx_resp_data_err);
  assign resp_timeout = r_resp_timeout;
  assign resp_valid   = r_resp_valid;
  assign req_ready    = r_req_ready;
  assign req_type_q   = r_req_type_q;
  assign busy         = r_busy;
  assign ti_ctrl      = r_ti_ctrl;

endmodule

// File: tb/tb_testio_host_fsm.sv
// Bench for testio_host_fsm: a behavioural transceiver/target drives ti_fsm_ctrl
// and every transaction's phase lengths and completion flags are compared.
module tb_testio_host_fsm;
  localparam int WR_C = 71;
  localparam int RD_C = 35;
  localparam int RT_C = 33;
  localparam int TO_C = 255;

  logic       ti_clk = 1'b0;
  logic       ti_rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_type = 1'b0;
  logic       resp_ready = 1'b0;
  logic       trx_resp_data_err = 1'b0;
  logic [5:0] ti_fsm_ctrl = 6'b000000;
  logic       req_ready, req_type_q, resp_valid, resp_err, resp_timeout, busy;
  logic [5:0] ti_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic typ, ack, stop, derr, hold, abort;
    int   delay, stall;
    logic exp_err, exp_to;
  } vec_t;

  vec_t vecs[12];

  testio_host_fsm #(.WR_HOST_CYC(WR_C), .RD_HOST_CYC(RD_C), .RD_TARG_CYC(RT_C),
                    .TIMEOUT_CYC(TO_C)) dut (
    .ti_clk(ti_clk), .ti_rstn(ti_rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_type_q(req_type_q), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_err(resp_err), .resp_timeout(resp_timeout),
    .trx_resp_data_err(trx_resp_data_err), .ti_fsm_ctrl(ti_fsm_ctrl),
    .ti_ctrl(ti_ctrl), .busy(busy)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge ti_clk);
    @(negedge ti_clk);
  endtask

  // Reset image: {req_ready, req_type_q, resp_valid, resp_err, resp_timeout, busy, ti_ctrl}
  task automatic check_reset_outputs(input string name);
    chk(name, 32'({req_ready, req_type_q, resp_valid, resp_err, resp_timeout, busy, ti_ctrl}),
        32'(12'b1000_0000_0000));
  endtask

  // Reference outcome from the protocol rules: {err, timeout}.
  function automatic logic [1:0] model(input vec_t v);
    logic to;
    logic err;
    to  = (v.delay >= TO_C);
    err = to ? 1'b0 : (v.typ ? (!v.ack || !v.stop) : v.derr);
    return {err, to};
  endfunction

  task automatic run_txn(input vec_t v);
    int waits, s, r, z, drain, bad, accepts, reload, exp_wait;
    logic rcv_end, to_exp, rd_path;
    logic [5:0] fc, exp_c;
    waits = 0; s = 0; r = 0; z = 0; drain = 0; bad = 0; rcv_end = 1'b0;
    while (!req_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk("req_ready_before_request", 32'(req_ready), 1);
    req_type = v.typ;
    req_valid = 1'b1;
    trx_resp_data_err = v.derr;
    resp_ready = 1'b0;
    accepts = req_ready ? 1 : 0;
    tick();
    if (!v.hold) req_valid = 1'b0;
    reload = v.typ ? WR_C : RD_C;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (resp_valid) break;
      if (v.abort && r == 10) begin
        ti_rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset_mid_rcv");
        return;
      end
      if (req_valid && req_ready) accepts++;
      fc = {1'b0, v.ack, 1'b0, v.stop, 1'b0, 1'b0};
      if (ti_ctrl[4] || ti_ctrl[3]) begin
        exp_c = (s == 0) ? {1'b1, v.typ, ~v.typ, 3'b010} : {1'b0, v.typ, ~v.typ, 3'b011};
        if (ti_ctrl != exp_c) bad++;
        // send_done is also raised in the entry cycle to model a stale counter.
        fc[0] = (s == 0) || (s == reload);
        s++;
      end else if (ti_ctrl[2]) begin
        if (rcv_end) begin
          drain++;
          if (ti_ctrl != 6'b100100) bad++;
        end else begin
          exp_c = (r == 0) ? 6'b100100 : 6'b000101;
          if (ti_ctrl != exp_c) bad++;
          fc[1] = (r == 0) || (r == RT_C);
          if (r == RT_C) rcv_end = 1'b1;
          r++;
        end
      end else if (busy && s > 0 && r == 0) begin
        if (ti_ctrl[4:0] != 5'b00000) bad++;
        fc[5] = (z >= v.delay);
        z++;
      end else begin
        bad++;
      end
      ti_fsm_ctrl = fc;
      tick();
    end
    chk("resp_valid_reached", 32'(resp_valid), 1);
    to_exp   = (v.delay >= TO_C);
    rd_path  = !v.typ && !to_exp;
    exp_wait = to_exp ? TO_C : (v.delay + 1 + (v.typ ? 2 : 0));
    chk("send_cycles", s, reload + 1);
    chk("wait_and_ack_cycles", z, exp_wait);
    chk("rcv_cycles", r, rd_path ? RT_C + 1 : 0);
    chk("drain_cycles", drain, rd_path ? 1 : 0);
    chk("ti_ctrl_pattern_bad", bad, 0);
    chk("accepts_per_txn", accepts, 1);
    // {req_ready, resp_valid, resp_err, resp_timeout, busy, req_type_q}
    for (int k = 0; k <= v.stall; k++) begin
      chk("resp_flags", 32'({req_ready, resp_valid, resp_err, resp_timeout, busy, req_type_q}),
          32'({1'b0, 1'b1, v.exp_err, v.exp_to, 1'b1, v.typ}));
      if (k < v.stall) tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    ti_fsm_ctrl = 6'b000000;
    // {resp_valid, resp_err, resp_timeout, busy, req_ready}
    chk("after_accept", 32'({resp_valid, resp_err, resp_timeout, busy, req_ready}), 1);
  endtask

  initial begin
    vec_t v;
    logic [1:0] m;
    int pick;
    //          typ   ack   stop  derr  hold  abort delay stall err   to
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2,   0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2,   0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,   0,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 300, 0,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 254, 0,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 255, 0,  1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3,   10, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0,   10, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1,   0,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5,   0,  1'b0, 1'b0};

    @(negedge ti_clk);
    @(negedge ti_clk);
    check_reset_outputs("reset_values");
    ti_rstn = 1'b1;
    tick();
    check_reset_outputs("idle_after_release");

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in the middle of a read response, then a clean write.
    v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
    run_txn(v);
    req_valid = 1'b0;
    ti_fsm_ctrl = 6'b000000;
    tick();
    tick();
    check_reset_outputs("reset_held");
    ti_rstn = 1'b1;
    tick();
    tick();
    tick();
    chk("no_completion_after_reset", 32'({resp_valid, busy, req_ready}), 1);
    run_txn(vecs[0]);

    for (int n = 0; n < 24; n++) begin
      v.typ   = 1'($urandom_range(0, 1));
      v.ack   = 1'($urandom_range(0, 1));
      v.stop  = 1'($urandom_range(0, 1));
      v.derr  = 1'($urandom_range(0, 1));
      v.hold  = 1'($urandom_range(0, 1));
      v.abort = 1'b0;
      pick    = int'($urandom_range(0, 9));
      v.delay = (pick < 8) ? int'($urandom_range(0, 6)) :
                ((pick == 8) ? 254 : 255 + int'($urandom_range(0, 3)));
      v.stall = int'($urandom_range(0, 3));
      m = model(v);
      v.exp_err = m[1];
      v.exp_to  = m[0];
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
